// File: rtl/wb_stim_responder_pkg.sv
// Shared definitions for the Wishbone stimulus responder.
// Contents:
//   - FSM state encoding (state_t plus ST_* constants)
//   - bus/lane geometry of the 128-bit data path
//   - default filler instruction word
//   - place_lane(): builds a 128-bit read beat from one 32-bit word
package wb_stim_responder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    localparam int unsigned LANE_W    = 32;
    localparam int unsigned BUS_W     = 128;
    localparam int unsigned NUM_LANES = 4;

    localparam logic [31:0] FILL_INST_DEFAULT = 32'hF0801003;

    // All lanes carry the filler; when use_word is set, the selected lane
    // carries the queued instruction instead.
    function automatic logic [BUS_W-1:0] place_lane(
        input logic [LANE_W-1:0] word,
        input logic [1:0]        lane,
        input logic [LANE_W-1:0] fill,
        input logic              use_word
    );
        logic [BUS_W-1:0] beat;
        beat = {NUM_LANES{fill}};
        if (use_word) begin
            beat[{lane, 5'd0} +: LANE_W] = word;
        end else begin
            beat = {NUM_LANES{fill}};
        end
        return beat;
    endfunction

endpackage

// File: rtl/wb_stim_fifo.sv
// Instruction queue for the stimulus responder.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push, push_data     enqueue request and word
//   pop                 dequeue request (ignored when empty)
//   head                word at the read pointer
//   count, full, empty  occupancy
// A push while full is still taken when a pop happens in the same cycle.
module wb_stim_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop_s, do_push_s;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == {CW{1'b0}});
    assign count    = count_q;
    assign head     = mem_q[rd_ptr_q];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= {AW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the queue is empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/wb_stim_responder.sv
// Wishbone slave model that feeds queued instruction words to a core.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   inst_valid/inst_data/inst_ready   instruction push interface
//   o_wb_*  (inputs)                  core master signals, core naming kept
//   i_wb_*  (outputs)                 read data, ack, err back to the core
//   wr_valid/wr_adr/wr_sel/wr_data    one-cycle capture of core writes
//   fetch_adr                         address of the last terminated read
//   queue_count                       instruction queue occupancy
// All response actions (pop, capture, ack/err) happen on the edge that
// enters RESP, so the registered outputs are visible during RESP.
module wb_stim_responder
    import wb_stim_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] FILL_INST   = FILL_INST_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inst_valid,
    input  logic [31:0]                inst_data,
    output logic                       inst_ready,
    input  logic [31:0]                o_wb_adr,
    input  logic [15:0]                o_wb_sel,
    input  logic                       o_wb_we,
    input  logic [127:0]               o_wb_dat,
    input  logic                       o_wb_cyc,
    input  logic                       o_wb_stb,
    output logic [127:0]               i_wb_dat,
    output logic                       i_wb_ack,
    output logic                       i_wb_err,
    output logic                       wr_valid,
    output logic [31:0]                wr_adr,
    output logic [15:0]                wr_sel,
    output logic [127:0]               wr_data,
    output logic [31:0]                fetch_adr,
    output logic [$clog2(DEPTH+1)-1:0] queue_count
);
    state_t         state_q, state_d;
    logic [3:0]     wait_cnt_q, wait_cnt_d;
    logic [31:0]    adr_q, adr_d;
    logic [15:0]    sel_q, sel_d;
    logic           we_q, we_d;
    logic [127:0]   dat_q, dat_d;
    logic           ack_q, ack_d;
    logic           err_q, err_d;
    logic [127:0]   rdat_q, rdat_d;
    logic           wr_valid_q, wr_valid_d;
    logic [31:0]    wr_adr_q, wr_adr_d;
    logic [15:0]    wr_sel_q, wr_sel_d;
    logic [127:0]   wr_data_q, wr_data_d;
    logic [31:0]    fetch_adr_q, fetch_adr_d;
    logic           term_s, pop_s;
    logic           full_s, empty_s;
    logic [31:0]    head_s;
    logic [31:0]    cur_adr_s;
    logic [15:0]    cur_sel_s;
    logic           cur_we_s;
    logic [127:0]   cur_dat_s;

    wb_stim_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inst_valid),
        .push_data (inst_data),
        .pop       (pop_s),
        .head      (head_s),
        .count     (queue_count),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign inst_ready = !full_s;
    assign i_wb_dat   = rdat_q;
    assign i_wb_ack   = ack_q;
    assign i_wb_err   = err_q;
    assign wr_valid   = wr_valid_q;
    assign wr_adr     = wr_adr_q;
    assign wr_sel     = wr_sel_q;
    assign wr_data    = wr_data_q;
    assign fetch_adr  = fetch_adr_q;

    // With zero wait states the response is decided in IDLE, before the
    // request has been latched, so take the live bus values there.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_adr_s = o_wb_adr;
            cur_sel_s = o_wb_sel;
            cur_we_s  = o_wb_we;
            cur_dat_s = o_wb_dat;
        end else begin
            cur_adr_s = adr_q;
            cur_sel_s = sel_q;
            cur_we_s  = we_q;
            cur_dat_s = dat_q;
        end
    end

    // FSM sequencing and response/capture next-state.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        we_d        = we_q;
        dat_d       = dat_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        rdat_d      = 128'd0;
        wr_valid_d  = 1'b0;
        wr_adr_d    = wr_adr_q;
        wr_sel_d    = wr_sel_q;
        wr_data_d   = wr_data_q;
        fetch_adr_d = fetch_adr_q;
        term_s      = 1'b0;
        pop_s       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (o_wb_cyc && o_wb_stb) begin
                    adr_d = o_wb_adr;
                    sel_d = o_wb_sel;
                    we_d  = o_wb_we;
                    dat_d = o_wb_dat;
                    if (WAIT_CYCLES == 32'd0) begin
                        term_s  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        wait_cnt_d = 4'(WAIT_CYCLES - 32'd1);
                        state_d    = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!o_wb_cyc) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == 4'd0) begin
                    term_s  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Zero byte-select terminates with err and has no side effect
        // other than recording the fetch address of a read.
        if (term_s) begin
            if (cur_sel_s == 16'd0) begin
                err_d = 1'b1;
                if (!cur_we_s) begin
                    fetch_adr_d = cur_adr_s;
                end else begin
                    fetch_adr_d = fetch_adr_q;
                end
            end else if (cur_we_s) begin
                ack_d      = 1'b1;
                wr_valid_d = 1'b1;
                wr_adr_d   = cur_adr_s;
                wr_sel_d   = cur_sel_s;
                wr_data_d  = cur_dat_s;
            end else begin
                ack_d       = 1'b1;
                fetch_adr_d = cur_adr_s;
                rdat_d      = place_lane(head_s, cur_adr_s[3:2], FILL_INST, !empty_s);
                pop_s       = !empty_s;
            end
        end else begin
            ack_d = 1'b0;
        end
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 4'd0;
            adr_q       <= 32'd0;
            sel_q       <= 16'd0;
            we_q        <= 1'b0;
            dat_q       <= 128'd0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdat_q      <= 128'd0;
            wr_valid_q  <= 1'b0;
            wr_adr_q    <= 32'd0;
            wr_sel_q    <= 16'd0;
            wr_data_q   <= 128'd0;
            fetch_adr_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            dat_q       <= dat_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdat_q      <= rdat_d;
            wr_valid_q  <= wr_valid_d;
            wr_adr_q    <= wr_adr_d;
            wr_sel_q    <= wr_sel_d;
            wr_data_q   <= wr_data_d;
            fetch_adr_q <= fetch_adr_d;
        end
    end

endmodule

// File: tb/tb_wb_stim_responder.sv
// Self-checking bench for wb_stim_responder (DEPTH=8, WAIT_CYCLES=1).
// Expected responses are queued when a request is driven and popped when
// the DUT terminates the cycle; a small queue models instruction order.
module tb_wb_stim_responder;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WAITC = 1;
    localparam logic [31:0] FILL  = 32'hF0801003;

    typedef struct {
        logic         is_err;
        logic         is_write;
        logic [31:0]  adr;
        logic [15:0]  sel;
        logic [127:0] dat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         inst_valid;
    logic [31:0]  inst_data;
    logic         inst_ready;
    logic [31:0]  o_wb_adr;
    logic [15:0]  o_wb_sel;
    logic         o_wb_we;
    logic [127:0] o_wb_dat;
    logic         o_wb_cyc;
    logic         o_wb_stb;
    logic [127:0] i_wb_dat;
    logic         i_wb_ack;
    logic         i_wb_err;
    logic         wr_valid;
    logic [31:0]  wr_adr;
    logic [15:0]  wr_sel;
    logic [127:0] wr_data;
    logic [31:0]  fetch_adr;
    logic [3:0]   queue_count;

    int total = 0;
    int bad   = 0;
    exp_t        sb[$];
    logic [31:0] model_q[$];
    logic [31:0] last_fetch = 32'd0;

    wb_stim_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC), .FILL_INST(FILL)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_valid (inst_valid),
        .inst_data  (inst_data),
        .inst_ready (inst_ready),
        .o_wb_adr   (o_wb_adr),
        .o_wb_sel   (o_wb_sel),
        .o_wb_we    (o_wb_we),
        .o_wb_dat   (o_wb_dat),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .i_wb_dat   (i_wb_dat),
        .i_wb_ack   (i_wb_ack),
        .i_wb_err   (i_wb_err),
        .wr_valid   (wr_valid),
        .wr_adr     (wr_adr),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .fetch_adr  (fetch_adr),
        .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        @(negedge clk);
        inst_valid = 1'b1;
        inst_data  = w;
        if (inst_ready) model_q.push_back(w);
        @(negedge clk);
        inst_valid = 1'b0;
    endtask

    // Waits for termination, checks latency and the popped expectation,
    // then checks that every response strobe lasts exactly one cycle.
    task automatic wait_resp();
        exp_t e;
        int   lat;
        logic seen;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 16) begin
            @(negedge clk);
            lat++;
            if (i_wb_ack || i_wb_err) seen = 1'b1;
        end
        e = sb.pop_front();
        if (!seen) begin
            chk("timeout", 128'd0, 128'd1);
        end else begin
            chk("latency", 128'(lat), 128'(WAITC + 1));
            chk("ack", 128'(i_wb_ack), 128'(!e.is_err));
            chk("err", 128'(i_wb_err), 128'(e.is_err));
            chk("rdata", i_wb_dat, e.is_err ? 128'd0 : (e.is_write ? 128'd0 : e.dat));
            chk("wr_valid", 128'(wr_valid), 128'(e.is_write && !e.is_err));
            if (e.is_write) begin
                chk("wr_adr", 128'(wr_adr), 128'(e.adr));
                chk("wr_sel", 128'(wr_sel), 128'(e.sel));
                chk("wr_data", wr_data, e.dat);
            end else begin
                chk("fetch_adr", 128'(fetch_adr), 128'(e.adr));
            end
        end
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        inst_valid = 1'b0;
        @(negedge clk);
        chk("ack_one_cycle", 128'({i_wb_ack, i_wb_err, wr_valid}), 128'd0);
        chk("rdata_idle", i_wb_dat, 128'd0);
        chk("queue_count", 128'(queue_count), 128'(model_q.size()));
    endtask

    task automatic do_read(input logic [31:0] adr, input logic [15:0] sel,
                           input logic push_also, input logic [31:0] pw);
        exp_t e;
        e.is_err   = (sel == 16'd0);
        e.is_write = 1'b0;
        e.adr      = adr;
        e.sel      = sel;
        e.dat      = {4{FILL}};
        if (!e.is_err) begin
            if (model_q.size() > 0) begin
                e.dat[adr[3:2]*32 +: 32] = model_q.pop_front();
            end
            last_fetch = adr;
        end else begin
            last_fetch = adr;
        end
        if (push_also) model_q.push_back(pw);
        sb.push_back(e);
        @(negedge clk);
        o_wb_cyc = 1'b1;
        o_wb_stb = 1'b1;
        o_wb_we  = 1'b0;
        o_wb_adr = adr;
        o_wb_sel = sel;
        if (push_also) begin
            inst_valid = 1'b1;
            inst_data  = pw;
        end
        wait_resp();
    endtask

    task automatic do_write(input logic [31:0] adr, input logic [15:0] sel, input logic [127:0] dat);
        exp_t e;
        e.is_err   = 1'b0;
        e.is_write = 1'b1;
        e.adr      = adr;
        e.sel      = sel;
        e.dat      = dat;
        sb.push_back(e);
        @(negedge clk);
        o_wb_cyc = 1'b1;
        o_wb_stb = 1'b1;
        o_wb_we  = 1'b1;
        o_wb_adr = adr;
        o_wb_sel = sel;
        o_wb_dat = dat;
        wait_resp();
        o_wb_we = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        inst_valid = 1'b0;
        inst_data  = 32'd0;
        o_wb_adr   = 32'd0;
        o_wb_sel   = 16'd0;
        o_wb_we    = 1'b0;
        o_wb_dat   = 128'd0;
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_ack", 128'({i_wb_ack, i_wb_err, wr_valid}), 128'd0);
        chk("rst_dat", i_wb_dat, 128'd0);
        chk("rst_count", 128'(queue_count), 128'd0);
        chk("rst_ready", 128'(inst_ready), 128'd1);
        chk("rst_fetch", 128'(fetch_adr), 128'd0);

        // Single queued word, lane 0, compared against a literal beat too
        push_word(32'hE3A01005);
        chk("count_after_push", 128'(queue_count), 128'd1);
        do_read(32'h0, 16'hFFFF, 1'b0, 32'd0);
        chk("lit_beat_lane0", 128'hF0801003F0801003F0801003E3A01005,
            {FILL, FILL, FILL, 32'hE3A01005});

        // Empty queue read
        do_read(32'h8, 16'hFFFF, 1'b0, 32'd0);
        chk("empty_fetch", 128'(fetch_adr), 128'h8);

        // Other lanes
        push_word(32'h11111111);
        push_word(32'h22222222);
        do_read(32'hC, 16'hFFFF, 1'b0, 32'd0);
        do_read(32'h4, 16'h00F0, 1'b0, 32'd0);

        // Write capture leaves the queue alone
        push_word(32'h33333333);
        do_write(32'h100, 16'h000F, 128'h0123456789ABCDEF00112233DEADBEEF);
        chk("fetch_kept_on_write", 128'(fetch_adr), 128'(last_fetch));
        do_read(32'h0, 16'hFFFF, 1'b0, 32'd0);

        // Fill the queue, then read with a simultaneous push and drain across wrap
        for (int i = 0; i < 8; i++) begin
            push_word(32'hA0000000 + 32'(i));
            if (i == 6) chk("ready_at_7", 128'(inst_ready), 128'd1);
        end
        chk("ready_full", 128'(inst_ready), 128'd0);
        chk("count_full", 128'(queue_count), 128'd8);
        do_read(32'h0, 16'hFFFF, 1'b1, 32'hA0000008);
        chk("count_push_pop_full", 128'(queue_count), 128'd8);
        for (int i = 0; i < 8; i++) begin
            do_read(32'h0, 16'hFFFF, 1'b0, 32'd0);
        end
        chk("count_drained", 128'(queue_count), 128'd0);

        // Zero byte-select terminates with err and does not pop
        push_word(32'h44444444);
        do_read(32'h40, 16'h0000, 1'b0, 32'd0);
        chk("err_fetch", 128'(fetch_adr), 128'h40);

        // Abort during WAIT
        @(negedge clk);
        o_wb_cyc = 1'b1;
        o_wb_stb = 1'b1;
        o_wb_adr = 32'h0;
        o_wb_sel = 16'hFFFF;
        @(negedge clk);
        o_wb_cyc = 1'b0;
        o_wb_stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_resp", 128'({i_wb_ack, i_wb_err}), 128'd0);
        end
        chk("abort_count", 128'(queue_count), 128'(model_q.size()));

        // Reset during WAIT with three words queued
        push_word(32'h55555555);
        push_word(32'h66666666);
        chk("pre_rst_count", 128'(queue_count), 128'd3);
        @(negedge clk);
        o_wb_cyc = 1'b1;
        o_wb_stb = 1'b1;
        o_wb_adr = 32'h20;
        o_wb_sel = 16'hFFFF;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_count", 128'(queue_count), 128'd0);
        chk("mid_rst_ready", 128'(inst_ready), 128'd1);
        chk("mid_rst_strobes", 128'({i_wb_ack, i_wb_err, wr_valid}), 128'd0);
        chk("mid_rst_wr_adr", 128'(wr_adr), 128'd0);
        chk("mid_rst_wr_sel", 128'(wr_sel), 128'd0);
        chk("mid_rst_wr_data", wr_data, 128'd0);
        chk("mid_rst_fetch", 128'(fetch_adr), 128'd0);
        model_q.delete();
        @(negedge clk);
        o_wb_cyc = 1'b0;
        o_wb_stb = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_ack", 128'({i_wb_ack, i_wb_err}), 128'd0);
        end
        chk("post_rst_count", 128'(queue_count), 128'd0);

        // Queue still works after reset
        push_word(32'h77777777);
        do_read(32'h8, 16'hFFFF, 1'b0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
